vending_controller: RTL and testbench
=====================================

# vending_controller

Sequencing and arbitration controller for the coin-operated vending datapath. It merges two physical coin slots (A and B) into one shared credit accumulator, arbitrating round-robin when both slots present a coin in the same cycle. It drives the dispenser through a req/ack handshake with timeout, and returns change or refunds as a train of 5-unit `chg5` pulses. It sits between the coin acceptors and cancel button on one side and the dispenser motor and change hopper on the other.

## Interface
- `PRICE_UNITS`, default 4: product price in 5-unit steps (4 = 20). Legal range 1..13.
- `ACK_TIMEOUT`, default 8: maximum cycles `disp_req` waits for `disp_ack` before aborting. Legal range 1..255.

Ports:
- `clk` in 1: single clock; all state changes on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `coin_a` in 2: slot A coin code. 01 = 5, 10 = 10, 00 and 11 = no coin.
- `coin_b` in 2: slot B coin code, same encoding as `coin_a`.
- `cancel` in 1: refund request, level sampled each cycle.
- `disp_ack` in 1: dispenser has taken the product.
- `disp_req` out 1: dispense request (registered).
- `chg5` out 1: one 5-unit coin returned per high cycle (registered).
- `coin_rej_a` out 1: 1-cycle pulse; slot A coin rejected.
- `coin_rej_b` out 1: 1-cycle pulse; slot B coin rejected.
- `fault` out 1: 1-cycle pulse on dispenser ack timeout.
- `busy` out 1: high in VEND or CHANGE.
- `credit` out 4: current credit in 5-unit steps.

## Operation
- States: COLLECT, VEND, CHANGE. Reset state is COLLECT.
- Reset values: all outputs 0, `credit` = 0, round-robin pointer = A, timeout counter = 0.
- **COLLECT, coin handling:**
  - A valid coin (01/10) on exactly one slot is accepted: `credit` increases by 1 or 2 at that edge.
  - Both slots valid in the same cycle: accept the slot named by the RR pointer, pulse the other slot's `coin_rej_*` next cycle, then flip the pointer. The pointer flips only on such conflicts.
  - Codes 00 and 11 are ignored silently, with no reject pulse.
- **COLLECT → VEND:** taken at the same edge at which the updated credit becomes ≥ `PRICE_UNITS`. `disp_req` = 1 from that edge.
- **Cancel in COLLECT:**
  - `cancel` = 1 with `credit` > 0: go to CHANGE to refund all credit. Any coins presented that cycle are rejected.
  - `cancel` with `credit` = 0: ignored.
  - Cancel takes priority over a coin in the same cycle.
- **VEND:**
  - `disp_req` is held at 1 until `disp_ack` is sampled at 1.
  - On that edge: `disp_req` → 0 and `credit` → `credit` − `PRICE_UNITS`. Go to CHANGE if the remainder is > 0, otherwise to COLLECT.
  - `cancel` is ignored in VEND.
- **VEND timeout:**
  - The counter counts cycles in VEND.
  - If `ACK_TIMEOUT` cycles elapse without ack: `disp_req` → 0, `fault` pulses, and the state goes to CHANGE with the full credit retained (full refund).
  - An ack arriving on the same edge as the timeout counts as success.
- **CHANGE:**
  - `chg5` alternates 1 cycle high, 1 cycle low. `credit` decrements on each high cycle.
  - After the last pulse's low cycle, with `credit` = 0, return to COLLECT.
- **Coins outside COLLECT:** any valid coin in VEND or CHANGE is rejected on its slot, with a pulse next cycle.
- **Width rule:** the maximum credit is `PRICE_UNITS` − 1 + 2 ≤ 15, so the 4-bit credit cannot overflow. No saturation logic is required.
- **Reset mid-operation:** asserting `rst` in any state immediately forces all outputs to their reset values. Credit is lost; there is no partial refund.

## Timing
- Coin to `credit` update: 1 edge.
- Coin to `disp_req`: 1 edge, on the same edge as the qualifying credit update.
- `disp_ack` to `disp_req` low: 1 edge.
- First `chg5` high follows the CHANGE entry edge by 1 cycle. N units produce N pulses over 2N cycles.
- Reject pulses occur 1 cycle after the offending coin and last exactly 1 cycle.
- `fault` rises `ACK_TIMEOUT` cycles after VEND entry, for 1 cycle.
- `busy` is registered and is high exactly while the state is not COLLECT.

## Test plan
- **Basic vend:** A=10, then A=10 → `credit` 2, then 4. `disp_req` = 1 on the second coin edge. Ack 3 cycles later → `disp_req` = 0, `credit` = 0, no `chg5`, `busy` = 0.
- **Arbitration:**
  - A=10 and B=5 in the same cycle → A accepted (`credit` 2), `coin_rej_b` pulses.
  - Then A=10 and B=10 in the same cycle → B accepted (`credit` 4, vend), `coin_rej_a` pulses.
- **Change:** 10, 5, 10 on A → `credit` 5, vend. On ack, `credit` 1 → one `chg5` pulse → `credit` 0, state COLLECT.
- **Cancel:**
  - 5, 5, then cancel → two `chg5` pulses separated by a low cycle, `credit` 0.
  - Cancel with `credit` 0 → no activity.
  - Cancel together with a coin → coin rejected.
- **Timeout:** reach credit 4 and never ack → after 8 cycles, `disp_req` = 0 and `fault` pulses. Then four `chg5` pulses; a coin presented during refund gets `coin_rej_*`.
- **Invalid code and reset:**
  - Code 11 on either slot → no credit change, no reject.
  - `rst` low mid-CHANGE → `chg5`, `busy` and `credit` go to 0 immediately. Normal vend works after release.

Source files
------------

// File: rtl/vending_controller.sv
// vending_controller: merges two coin slots into a shared credit, arbitrates
// round-robin on same-cycle coins, runs a req/ack dispense handshake with a
// timeout, and pays out change or refunds as a train of 5-unit chg5 pulses.
module vending_controller #(
  parameter int unsigned PRICE_UNITS = 4,  // price in 5-unit steps, 1..13
  parameter int unsigned ACK_TIMEOUT = 8   // cycles to wait for disp_ack, 1..255
) (
  input  logic       clk,
  input  logic       rst,           // asynchronous, active-low
  input  logic [1:0] coin_a_i,
  input  logic [1:0] coin_b_i,
  input  logic       cancel_i,
  input  logic       disp_ack_i,
  output logic       disp_req_o,
  output logic       chg5_o,
  output logic       coin_rej_a_o,
  output logic       coin_rej_b_o,
  output logic       fault_o,
  output logic       busy_o,
  output logic [3:0] credit_o
);

  typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

  localparam logic [3:0] PRICE   = 4'(PRICE_UNITS);
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state_q;
  logic [3:0] credit_q;
  logic       rr_b_q;        // 0: slot A wins the next conflict, 1: slot B
  logic [7:0] wait_cnt_q;    // cycles already spent in VEND without ack
  logic       disp_req_q;
  logic       chg5_q;
  logic       rej_a_q;
  logic       rej_b_q;
  logic       fault_q;
  logic       busy_q;

  // Codes 01 and 10 are the only valid coins; the code value equals its units.
  logic       valid_a, valid_b;
  logic       take_a, take_b;
  logic [3:0] add_units;
  logic [3:0] credit_d;

  assign valid_a = coin_a_i[1] ^ coin_a_i[0];
  assign valid_b = coin_b_i[1] ^ coin_b_i[0];

  // Pick which slot is credited in COLLECT and the resulting credit.
  always_comb begin
    take_a    = 1'b0;
    take_b    = 1'b0;
    add_units = 4'd0;
    if (valid_a && valid_b) begin
      take_a = ~rr_b_q;
      take_b = rr_b_q;
    end else begin
      take_a = valid_a;
      take_b = valid_b;
    end
    if (take_a) begin
      add_units = {2'b00, coin_a_i};
    end else if (take_b) begin
      add_units = {2'b00, coin_b_i};
    end
    credit_d = credit_q + add_units;
  end

  // Controller FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= COLLECT;
      credit_q   <= 4'd0;
      rr_b_q     <= 1'b0;
      wait_cnt_q <= 8'd0;
      disp_req_q <= 1'b0;
      chg5_q     <= 1'b0;
      rej_a_q    <= 1'b0;
      rej_b_q    <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rej_a_q <= 1'b0;
      rej_b_q <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (cancel_i && (credit_q != 4'd0)) begin
            // Cancel wins over coins: refund everything, bounce this cycle's coins.
            state_q <= CHANGE;
            busy_q  <= 1'b1;
            chg5_q  <= 1'b0;
            rej_a_q <= valid_a;
            rej_b_q <= valid_b;
          end else begin
            rej_a_q  <= valid_a & ~take_a;
            rej_b_q  <= valid_b & ~take_b;
            credit_q <= credit_d;
            if (valid_a && valid_b) begin
              rr_b_q <= ~rr_b_q;
            end
            if (credit_d >= PRICE) begin
              state_q    <= VEND;
              busy_q     <= 1'b1;
              disp_req_q <= 1'b1;
              wait_cnt_q <= 8'd0;
            end
          end
        end
        VEND: begin
          rej_a_q <= valid_a;
          rej_b_q <= valid_b;
          if (disp_ack_i) begin
            // Ack wins even on the timeout edge.
            disp_req_q <= 1'b0;
            wait_cnt_q <= 8'd0;
            credit_q   <= credit_q - PRICE;
            if (credit_q > PRICE) begin
              state_q <= CHANGE;
              chg5_q  <= 1'b0;
            end else begin
              state_q <= COLLECT;
              busy_q  <= 1'b0;
            end
          end else if (wait_cnt_q == TO_LAST) begin
            // Dispenser never answered: keep full credit and refund it.
            disp_req_q <= 1'b0;
            fault_q    <= 1'b1;
            wait_cnt_q <= 8'd0;
            state_q    <= CHANGE;
            chg5_q     <= 1'b0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        CHANGE: begin
          rej_a_q <= valid_a;
          rej_b_q <= valid_b;
          if (chg5_q) begin
            chg5_q <= 1'b0;
          end else if (credit_q != 4'd0) begin
            chg5_q   <= 1'b1;
            credit_q <= credit_q - 4'd1;
          end else begin
            state_q <= COLLECT;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= COLLECT;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign disp_req_o   = disp_req_q;
  assign chg5_o       = chg5_q;
  assign coin_rej_a_o = rej_a_q;
  assign coin_rej_b_o = rej_b_q;
  assign fault_o      = fault_q;
  assign busy_o       = busy_q;
  assign credit_o     = credit_q;

endmodule

// File: tb/tb_vending_controller.sv
// Testbench for vending_controller: fixed vector table, hand-written corner
// sequences and random traffic, all checked against a queue-based model.
module tb_vending_controller;

  localparam int PRICE   = 4;
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] coin_a = 2'b00;
  logic [1:0] coin_b = 2'b00;
  logic       cancel = 1'b0;
  logic       disp_ack = 1'b0;
  logic       disp_req, chg5, coin_rej_a, coin_rej_b, fault, busy;
  logic [3:0] credit;

  int n_checks = 0;
  int n_fail   = 0;

  vending_controller #(.PRICE_UNITS(PRICE), .ACK_TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_a_i     (coin_a),
    .coin_b_i     (coin_b),
    .cancel_i     (cancel),
    .disp_ack_i   (disp_ack),
    .disp_req_o   (disp_req),
    .chg5_o       (chg5),
    .coin_rej_a_o (coin_rej_a),
    .coin_rej_b_o (coin_rej_b),
    .fault_o      (fault),
    .busy_o       (busy),
    .credit_o     (credit)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit chg;
    int credit;
    bit busy;
  } refund_t;

  refund_t refund_q[$];   // scheduled per-edge outputs of a pending payout
  int m_credit, m_rr, m_waited;
  bit m_vending;
  bit m_req, m_chg, m_rej_a, m_rej_b, m_fault, m_busy;

  task automatic model_reset();
    refund_q.delete();
    m_credit = 0; m_rr = 0; m_waited = 0; m_vending = 0;
    m_req = 0; m_chg = 0; m_rej_a = 0; m_rej_b = 0; m_fault = 0; m_busy = 0;
  endtask

  // Pay out n units: entry edge shows chg5 low, then n high/low pairs, then idle.
  task automatic start_refund(int n);
    refund_t e;
    m_credit = n; m_chg = 0; m_busy = 1;
    for (int i = 1; i <= n; i++) begin
      e.chg = 1; e.credit = n - i; e.busy = 1; refund_q.push_back(e);
      e.chg = 0; e.credit = n - i; e.busy = 1; refund_q.push_back(e);
    end
    e.chg = 0; e.credit = 0; e.busy = 0; refund_q.push_back(e);
  endtask

  task automatic model_step(int a, int b, bit cc, bit ack);
    bit va, vb;
    refund_t e;
    va = (a == 1) || (a == 2);
    vb = (b == 1) || (b == 2);
    m_rej_a = 0; m_rej_b = 0; m_fault = 0;
    if (refund_q.size() > 0) begin
      m_rej_a = va; m_rej_b = vb;
      e = refund_q.pop_front();
      m_chg = e.chg; m_credit = e.credit; m_busy = e.busy;
    end else if (m_vending) begin
      m_rej_a = va; m_rej_b = vb;
      if (ack) begin
        m_vending = 0; m_req = 0;
        if (m_credit - PRICE > 0) start_refund(m_credit - PRICE);
        else begin m_credit = 0; m_busy = 0; end
      end else begin
        m_waited++;
        if (m_waited == TIMEOUT) begin
          m_vending = 0; m_req = 0; m_fault = 1;
          start_refund(m_credit);
        end
      end
    end else begin
      if (cc && m_credit > 0) begin
        m_rej_a = va; m_rej_b = vb;
        start_refund(m_credit);
      end else begin
        if (va && vb) begin
          if (m_rr == 0) begin m_credit += a; m_rej_b = 1; end
          else begin m_credit += b; m_rej_a = 1; end
          m_rr = 1 - m_rr;
        end else if (va) m_credit += a;
        else if (vb) m_credit += b;
        if (m_credit >= PRICE) begin
          m_vending = 1; m_waited = 0; m_req = 1; m_busy = 1;
        end
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    check({tag, ".credit"},   int'(credit),     m_credit);
    check({tag, ".disp_req"}, int'(disp_req),   int'(m_req));
    check({tag, ".chg5"},     int'(chg5),       int'(m_chg));
    check({tag, ".rej_a"},    int'(coin_rej_a), int'(m_rej_a));
    check({tag, ".rej_b"},    int'(coin_rej_b), int'(m_rej_b));
    check({tag, ".fault"},    int'(fault),      int'(m_fault));
    check({tag, ".busy"},     int'(busy),       int'(m_busy));
  endtask

  // One clock: drive inputs (called at negedge), step model at posedge, check at negedge.
  task automatic tick(string tag, logic [1:0] a, logic [1:0] b, logic cc, logic ack);
    coin_a = a; coin_b = b; cancel = cc; disp_ack = ack;
    @(posedge clk);
    model_step(int'(a), int'(b), cc, ack);
    @(negedge clk);
    check_model(tag);
    $display("%s a=%b b=%b cancel=%b ack=%b -> credit=%0d req=%b chg5=%b rej=%b%b fault=%b busy=%b",
             tag, a, b, cc, ack, credit, disp_req, chg5, coin_rej_a, coin_rej_b, fault, busy);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] a, b;
    logic       cc, ack;
    logic [3:0] credit;
    logic       req, chg, ra, rb, flt, bsy;
  } vec_t;

  vec_t vecs[22];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int fault_at, pulses;
    logic [1:0] ra, rb;
    logic rc, rk;

    // a, b, cancel, ack | credit, req, chg5, rej_a, rej_b, fault, busy
    vecs[0]  = '{2'b10, 2'b00, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'b10, 2'b00, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{2'b00, 2'b00, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{2'b00, 2'b00, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{2'b00, 2'b00, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{2'b10, 2'b01, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{2'b10, 2'b10, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{2'b00, 2'b00, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'b10, 2'b00, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{2'b01, 2'b00, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'b10, 2'b00, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{2'b00, 2'b00, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{2'b11, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{2'b00, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{2'b01, 2'b00, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{2'b00, 2'b10, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[19] = '{2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[20] = '{2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[21] = '{2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    model_reset();
    repeat (3) @(negedge clk);
    check("reset.outputs", int'({credit, disp_req, chg5, coin_rej_a, coin_rej_b, fault, busy}), 0);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven vectors: basic vend, arbitration, change, invalid code, cancel
    for (int i = 0; i < 22; i++) begin
      tick($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cc, vecs[i].ack);
      check($sformatf("vec%0d.table", i),
            int'({credit, disp_req, chg5, coin_rej_a, coin_rej_b, fault, busy}),
            int'({vecs[i].credit, vecs[i].req, vecs[i].chg, vecs[i].ra, vecs[i].rb,
                  vecs[i].flt, vecs[i].bsy}));
    end

    // Cancel after 5,5: two chg5 pulses with a low cycle between
    tick("can55", 2'b01, 2'b00, 1'b0, 1'b0);
    tick("can55", 2'b01, 2'b00, 1'b0, 1'b0);
    tick("can55", 2'b00, 2'b00, 1'b1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick("can55", 2'b00, 2'b00, 1'b0, 1'b0);
      if (chg5) pulses++;
    end
    check("can55.pulses", pulses, 2);
    check("can55.credit", int'(credit), 0);
    check("can55.busy", int'(busy), 0);

    // Timeout: credit 4, no ack; fault on the 8th VEND edge, then 4-unit refund
    tick("tmo", 2'b10, 2'b00, 1'b0, 1'b0);
    tick("tmo", 2'b10, 2'b00, 1'b0, 1'b0);
    fault_at = -1;
    for (int i = 1; i <= TIMEOUT + 1; i++) begin
      tick("tmo", 2'b00, 2'b00, 1'b0, 1'b0);
      if (fault && fault_at < 0) fault_at = i;
    end
    check("tmo.fault_cycle", fault_at, TIMEOUT);
    pulses = int'(chg5);
    tick("tmo.refund_coin", 2'b01, 2'b00, 1'b0, 1'b0);
    check("tmo.rej_a", int'(coin_rej_a), 1);
    if (chg5) pulses++;
    for (int i = 0; i < 8; i++) begin
      tick("tmo.refund", 2'b00, 2'b00, 1'b0, 1'b0);
      if (chg5) pulses++;
    end
    check("tmo.pulses", pulses, 4);
    check("tmo.busy", int'(busy), 0);

    // Reset in the middle of CHANGE, then a normal vend
    tick("rstmid", 2'b10, 2'b00, 1'b0, 1'b0);
    tick("rstmid", 2'b01, 2'b00, 1'b0, 1'b0);
    tick("rstmid", 2'b00, 2'b00, 1'b1, 1'b0);
    tick("rstmid", 2'b00, 2'b00, 1'b0, 1'b0);
    check("rstmid.chg5_before", int'(chg5), 1);
    rst = 1'b0;
    #1;
    model_reset();
    check("rstmid.chg5", int'(chg5), 0);
    check("rstmid.busy", int'(busy), 0);
    check("rstmid.credit", int'(credit), 0);
    @(negedge clk);
    rst = 1'b1;
    tick("postrst", 2'b00, 2'b10, 1'b0, 1'b0);
    tick("postrst", 2'b00, 2'b10, 1'b0, 1'b0);
    check("postrst.req", int'(disp_req), 1);
    tick("postrst", 2'b00, 2'b00, 1'b0, 1'b1);
    check("postrst.done", int'({credit, disp_req, busy}), 0);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      ra = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      rb = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      rc = ($urandom_range(0, 11) == 0);
      rk = ($urandom_range(0, 6) == 0);
      tick($sformatf("rnd%0d", i), ra, rb, rc, rk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
